// File: rtl/jt49_bus_ts.sv
// Bus front end for up to four PSG cores: decodes the original BDIR/BC1 bus,
// queues register writes in a small FIFO and replays them to the cores on clk_en.
module jt49_bus_ts #(
  parameter int         NCHIP   = 2,
  parameter int         DEPTH   = 4,
  parameter logic [3:0] ADDR_HI = 4'h0,
  localparam int        CW      = (NCHIP > 1) ? $clog2(NCHIP) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic                  bdir,
  input  logic                  bc1,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  output logic [NCHIP-1:0]      chip_cs_n,
  output logic                  chip_wr_n,
  output logic [3:0]            chip_addr,
  output logic [7:0]            chip_din,
  input  logic [8*NCHIP-1:0]    chip_dout,
  output logic [CW-1:0]         sel_chip,
  output logic                  busy,
  output logic                  ovf
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [CW-1:0] chip;
    logic [3:0]    addr;
    logic [7:0]    data;
  } entry_t;

  logic [1:0]       bus_r;
  logic [1:0]       bus_prev_r;
  logic [3:0]       addr_r;
  logic             addr_ok_r;
  logic [CW-1:0]    sel_r;
  entry_t           mem_r [DEPTH];
  logic [AW-1:0]    wptr_r;
  logic [AW-1:0]    rptr_r;
  logic [AW:0]      count_r;
  logic             busy_r;
  logic             ovf_r;
  logic [7:0]       dout_r;
  logic             chip_wr_n_r;
  logic [NCHIP-1:0] chip_cs_n_r;
  logic [3:0]       chip_addr_r;
  logic [7:0]       chip_din_r;

  logic             hit_s;
  logic [CW-1:0]    hit_idx_s;
  logic [7:0]       rd_s;
  logic             full_s;
  logic             pop_s;
  logic             push_s;
  logic             push_ok_s;
  logic [AW:0]      count_nxt_s;
  logic [NCHIP-1:0] cs_nxt_s;
  entry_t           head_s;
  entry_t           new_s;

  assign full_s    = (count_r == FULL_CNT);
  assign pop_s     = clk_en && (count_r != {(AW+1){1'b0}});
  // Only the first registered cycle of a write state pushes; holding the state does nothing more
  assign push_s    = (bus_r == 2'b10) && (bus_prev_r != 2'b10) && addr_ok_r;
  assign push_ok_s = push_s && (!full_s || pop_s);
  assign head_s    = mem_r[rptr_r];
  assign new_s     = '{chip: sel_r, addr: addr_r, data: din};

  // Chip-select codes FF, FE, ... on the latch cycle pick a core instead of a register
  always_comb begin
    hit_s     = 1'b0;
    hit_idx_s = {CW{1'b0}};
    for (int k = 0; k < NCHIP; k++) begin
      if (din == 8'(255 - k)) begin
        hit_s     = 1'b1;
        hit_idx_s = CW'(k);
      end else begin
        hit_s     = hit_s;
      end
    end
  end

  // Read-back mux of the selected core
  always_comb begin
    rd_s = 8'hFF;
    for (int k = 0; k < NCHIP; k++) begin
      if (sel_r == CW'(k)) begin
        rd_s = chip_dout[8*k +: 8];
      end else begin
        rd_s = rd_s;
      end
    end
  end

  // Occupancy update
  always_comb begin
    case ({push_ok_s, pop_s})
      2'b10:   count_nxt_s = count_r + (AW+1)'(1);
      2'b01:   count_nxt_s = count_r - (AW+1)'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Next chip selects: popped entry's core, else the selected core during a read
  always_comb begin
    cs_nxt_s = {NCHIP{1'b1}};
    for (int k = 0; k < NCHIP; k++) begin
      if (pop_s) begin
        cs_nxt_s[k] = (head_s.chip != CW'(k));
      end else if ((bus_r == 2'b01) && addr_ok_r) begin
        cs_nxt_s[k] = (sel_r != CW'(k));
      end else begin
        cs_nxt_s[k] = 1'b1;
      end
    end
  end

  // Bus state register and address/core latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_r      <= 2'b00;
      bus_prev_r <= 2'b00;
      addr_r     <= 4'h0;
      addr_ok_r  <= 1'b1;
      sel_r      <= {CW{1'b0}};
    end else begin
      bus_r      <= {bdir, bc1};
      bus_prev_r <= bus_r;
      case (bus_r)
        2'b11: begin
          if (hit_s) begin
            sel_r <= hit_idx_s;
          end else if (din[7:4] == ADDR_HI) begin
            addr_r    <= din[3:0];
            addr_ok_r <= 1'b1;
          end else begin
            addr_ok_r <= 1'b0;
          end
        end
        default: begin
          addr_r <= addr_r;
        end
      endcase
    end
  end

  // Write FIFO, occupancy and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wptr_r  <= {AW{1'b0}};
      rptr_r  <= {AW{1'b0}};
      count_r <= {(AW+1){1'b0}};
      busy_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      if (push_ok_s) begin
        mem_r[wptr_r] <= new_s;
        wptr_r        <= wptr_r + AW'(1);
      end
      if (pop_s) begin
        rptr_r <= rptr_r + AW'(1);
      end
      if (push_s && !push_ok_s) begin
        ovf_r <= 1'b1;
      end
      count_r <= count_nxt_s;
      busy_r  <= (count_nxt_s != {(AW+1){1'b0}});
    end
  end

  // Registered core-side strobes and CPU read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chip_wr_n_r <= 1'b1;
      chip_cs_n_r <= {NCHIP{1'b1}};
      chip_addr_r <= 4'h0;
      chip_din_r  <= 8'h00;
      dout_r      <= 8'hFF;
    end else begin
      chip_wr_n_r <= !pop_s;
      chip_cs_n_r <= cs_nxt_s;
      chip_addr_r <= pop_s ? head_s.addr : addr_r;
      if (pop_s) begin
        chip_din_r <= head_s.data;
      end
      if ((bus_r == 2'b01) && !pop_s) begin
        dout_r <= addr_ok_r ? rd_s : 8'hFF;
      end
    end
  end

  assign dout      = dout_r;
  assign chip_cs_n = chip_cs_n_r;
  assign chip_wr_n = chip_wr_n_r;
  assign chip_addr = chip_addr_r;
  assign chip_din  = chip_din_r;
  assign sel_chip  = sel_r;
  assign busy      = busy_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_jt49_bus_ts.sv
// Scoreboard bench for jt49_bus_ts: writes queue expected core strobes,
// a negedge monitor pops and compares every chip_wr_n pulse.
module tb_jt49_bus_ts;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_en;
  logic        bdir;
  logic        bc1;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic [1:0]  chip_cs_n;
  logic        chip_wr_n;
  logic [3:0]  chip_addr;
  logic [7:0]  chip_din;
  logic [15:0] chip_dout;
  logic [0:0]  sel_chip;
  logic        busy;
  logic        ovf;

  int tests = 0;
  int fails = 0;
  int en_mode = 0;

  typedef struct {
    logic [1:0] cs_n;
    logic [3:0] addr;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  jt49_bus_ts #(.NCHIP(2), .DEPTH(4), .ADDR_HI(4'h0)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .bdir(bdir), .bc1(bc1),
    .din(din), .dout(dout), .chip_cs_n(chip_cs_n), .chip_wr_n(chip_wr_n),
    .chip_addr(chip_addr), .chip_din(chip_din), .chip_dout(chip_dout),
    .sel_chip(sel_chip), .busy(busy), .ovf(ovf)
  );

  // clk_en pattern: 0 off, 1 every 4th clk, 2 always on, 3 driven by the main sequence
  initial begin
    int ph;
    ph = 0;
    clk_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ph++;
      case (en_mode)
        0: clk_en = 1'b0;
        1: clk_en = ((ph % 4) == 0);
        2: clk_en = 1'b1;
        default: ;
      endcase
    end
  end

  // Monitor: every strobe must match the oldest expected write
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && chip_wr_n === 1'b0) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL strobe: unexpected write cs_n=%b addr=%h din=%h", chip_cs_n, chip_addr, chip_din);
      end else begin
        e = sb.pop_front();
        if (chip_cs_n !== e.cs_n || chip_addr !== e.addr || chip_din !== e.data) begin
          fails++;
          $display("FAIL strobe: got cs_n=%b addr=%h din=%h, expected cs_n=%b addr=%h din=%h",
                   chip_cs_n, chip_addr, chip_din, e.cs_n, e.addr, e.data);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    bdir = 1'b0;
    bc1  = 1'b0;
  endtask

  task automatic latch(input logic [7:0] v);
    bdir = 1'b1; bc1 = 1'b1; din = v;
    cyc(2);
    bus_idle();
    cyc(1);
  endtask

  task automatic write(input logic [7:0] v, input logic [1:0] cs, input logic [3:0] a, input bit expect_push);
    if (expect_push) sb.push_back('{cs, a, v});
    bdir = 1'b1; bc1 = 1'b0; din = v;
    cyc(2);
    bus_idle();
    cyc(1);
  endtask

  task automatic read();
    bdir = 1'b0; bc1 = 1'b1;
    cyc(2);
    bus_idle();
    cyc(1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    en_mode = 1;
    while ((sb.size() != 0 || busy !== 1'b0) && n < 80) begin
      cyc(1);
      n++;
    end
    chk(name, (sb.size() == 0 && busy === 1'b0) ? 1 : 0, 1);
    en_mode = 0;
    cyc(8);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  initial begin
    rst_n = 1'b0;
    bdir = 1'b0; bc1 = 1'b0; din = 8'h00;
    chip_dout = {8'hB2, 8'hA1};
    cyc(3);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_dout", dout, 8'hFF);
    chk("rst_wr_n", chip_wr_n, 1);
    chk("rst_cs_n", chip_cs_n, 2'b11);
    chk("rst_din", chip_din, 8'h00);
    chk("rst_sel", sel_chip, 0);
    rst_n = 1'b1;
    cyc(2);

    // Single write to core 0, register 7
    latch(8'h07);
    write(8'h38, 2'b10, 4'h7, 1'b1);
    chk("single_busy", busy, 1);
    drain("single_drain");

    // Core select, write to core 1, then read-back from both cores
    latch(8'hFE);
    chk("sel_fe", sel_chip, 1);
    latch(8'h08);
    write(8'h0F, 2'b01, 4'h8, 1'b1);
    drain("core1_drain");
    latch(8'hFF);
    chk("sel_ff", sel_chip, 0);
    read();
    chk("read_core0", dout, 8'hA1);
    latch(8'hFE);
    read();
    chk("read_core1", dout, 8'hB2);

    // Invalid address high nibble: no push, read gives FF
    latch(8'h17);
    write(8'h55, 2'b01, 4'h8, 1'b0);
    chk("badaddr_busy", busy, 0);
    read();
    chk("badaddr_dout", dout, 8'hFF);
    drain("badaddr_drain");

    // Overflow: five writes with clk_en held low
    latch(8'hFF);
    latch(8'h07);
    for (int i = 1; i <= 5; i++) begin
      write(8'(i), 2'b10, 4'h7, i <= 4);
    end
    chk("ovf_set", ovf, 1);
    chk("ovf_busy", busy, 1);
    drain("ovf_drain");
    chk("ovf_sticky", ovf, 1);

    do_reset();
    chk("ovf_clear", ovf, 0);

    // Holding the write state for 10 clks pushes once
    sb.push_back('{2'b10, 4'h0, 8'hAA});
    bdir = 1'b1; bc1 = 1'b0; din = 8'hAA;
    cyc(10);
    bus_idle();
    cyc(1);
    drain("hold_drain");

    // Full FIFO with push and pop on the same cycle
    write(8'h11, 2'b10, 4'h0, 1'b1);
    write(8'h22, 2'b10, 4'h0, 1'b1);
    write(8'h33, 2'b10, 4'h0, 1'b1);
    write(8'h44, 2'b10, 4'h0, 1'b1);
    en_mode = 3;
    clk_en = 1'b0;
    sb.push_back('{2'b10, 4'h0, 8'hCC});
    bdir = 1'b1; bc1 = 1'b0; din = 8'hCC;
    cyc(1);
    clk_en = 1'b1;
    cyc(1);
    clk_en = 1'b0;
    bus_idle();
    cyc(1);
    chk("fullpp_ovf", ovf, 0);
    chk("fullpp_busy", busy, 1);
    drain("fullpp_drain");

    // Reset with three entries pending discards them
    write(8'h61, 2'b10, 4'h0, 1'b1);
    write(8'h62, 2'b10, 4'h0, 1'b1);
    write(8'h63, 2'b10, 4'h0, 1'b1);
    chk("pend_busy", busy, 1);
    #3;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wr_n", chip_wr_n, 1);
    chk("mid_rst_ovf", ovf, 0);
    cyc(2);
    rst_n = 1'b1;
    en_mode = 2;
    cyc(20);
    chk("post_rst_busy", busy, 0);
    en_mode = 0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jt49_bus_ts.md
JT49_BUS_TS -- requirements
Module: jt49_bus_ts

Interface
REQ-001 SHALL have parameter NCHIP, default 2, meaning number of PSG cores addressed (1..4).
REQ-002 SHALL have parameter DEPTH, default 4, meaning write-FIFO entries (power of two, 2..16).
REQ-003 SHALL have parameter ADDR_HI, default 4'h0, meaning required din[7:4] for a valid register address.
REQ-004 SHALL define CW = (NCHIP>1) ? clog2(NCHIP) : 1.
REQ-005 clk  input  1  system clock, all logic on posedge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 clk_en  input  1  PSG clock enable; FIFO drains only on cycles with clk_en=1.
REQ-008 bdir, bc1  input  1 each  original bus control pins.
REQ-009 din  input  8  CPU data bus.
REQ-010 dout  output  8  read data to CPU.
REQ-011 chip_cs_n  output  NCHIP  per-core chip select, active-low.
REQ-012 chip_wr_n  output  1  shared core write strobe, active-low.
REQ-013 chip_addr  output  4  shared core register address.
REQ-014 chip_din  output  8  shared core write data.
REQ-015 chip_dout  input  8*NCHIP  core read data, core k on bits [8k+7:8k].
REQ-016 sel_chip  output  CW  currently selected core.
REQ-017 busy  output  1  high while FIFO non-empty.
REQ-018 ovf  output  1  sticky overflow flag.

Function
REQ-019 Bus state {bdir,bc1} SHALL be registered once per clk; actions below trigger on registered state.
REQ-020 State 11 (latch): din = 8'hFF-k with k<NCHIP SHALL set sel_chip=k, addr unchanged; else if din[7:4]==ADDR_HI, addr<=din[3:0], addr_ok<=1; else addr_ok<=0.
REQ-021 State 10 (write): exactly one push of {sel_chip, addr, din} SHALL occur per bus write, on the first cycle of state 10, only if addr_ok=1; din sampled that cycle.
REQ-022 Holding state 10 for multiple cycles SHALL NOT cause extra pushes; a new push needs state to leave 10 and re-enter.
REQ-023 Push when FIFO full SHALL be dropped and set ovf=1; ovf clears only on reset.
REQ-024 Pop: on a clk cycle with clk_en=1 and FIFO non-empty, SHALL output head entry for one clk: chip_wr_n=0, chip_cs_n[k]=0 for entry's chip, chip_addr/chip_din = entry fields, then advance read pointer.
REQ-025 Outside a pop cycle: chip_wr_n=1, chip_addr=latched addr, chip_din=last popped data, chip_cs_n all 1 except sel_chip low during state 01 with addr_ok=1.
REQ-026 Simultaneous push and pop SHALL both occur; occupancy unchanged; pop takes older entry; push into full FIFO with simultaneous pop SHALL be accepted.
REQ-027 Pointers SHALL wrap modulo DEPTH; occupancy counter width clog2(DEPTH)+1.
REQ-028 State 01 (read), not a pop cycle: dout<= addr_ok ? chip_dout[sel_chip] : 8'hFF, one clk latency; during pop cycles and other states dout SHALL hold.
REQ-029 busy SHALL equal (occupancy != 0), registered with occupancy.
REQ-030 State 00 SHALL perform no action.
REQ-031 Writes to the same core SHALL reach it in bus order; order across cores SHALL also be preserved.

Reset
REQ-032 rst_n=0 SHALL asynchronously set: addr=0, addr_ok=1, sel_chip=0, FIFO empty (pointers, count =0), busy=0, ovf=0, dout=8'hFF, chip_wr_n=1, chip_cs_n all 1, chip_din=0, registered bus state=00.
REQ-033 Reset mid-operation SHALL discard all pending FIFO entries; no strobe after rst_n deasserts until a new write.

Verification
REQ-034 Latch 8'h07, write 8'h38, clk_en every 4 clks -> one chip_wr_n pulse, chip_cs_n[0]=0, chip_addr=7, chip_din=8'h38, busy 1 then 0.
REQ-035 NCHIP=2: latch 8'hFE, latch 8'h08, write 8'h0F -> pulse with chip_cs_n=2'b01, sel_chip=1; latch 8'hFF then read -> dout=chip_dout[7:0] after 1 clk.
REQ-036 clk_en=0, DEPTH=4, 5 writes of 8'h01..8'h05 -> ovf=1, busy=1; enable clk_en -> 4 pops in order 01..04, 05 absent.
REQ-037 Latch 8'h17 (ADDR_HI=0) then write -> no push; read -> dout=8'hFF.
REQ-038 Hold state 10 for 10 clks -> one push only; full FIFO with push and pop same cycle -> count stays DEPTH, ovf stays 0.
REQ-039 Assert rst_n=0 with 3 entries pending -> busy=0, no further chip_wr_n pulses, ovf=0.
